eship_fire_scheduler: RTL and testbench

- Upstream stage of the enemy-projectile controller. It decides when an enemy ship fires and which one.
- Produces a one-frame, one-hot fire request per ship (ESchedFire) and exposes its countdown (ESchedCtr).
- Paces shots with a jittered countdown. Selects shooters round-robin over live ships.
- Withholds requests while every projectile slot is busy, so no shot is dropped downstream.

---
 rtl/eship_fire_scheduler_pkg.sv | 23 ++
 rtl/eship_fire_scheduler_if.sv | 26 ++
 rtl/eship_fire_scheduler_lfsr10.sv | 22 ++
 rtl/eship_fire_scheduler.sv | 136 +++++++++++++
 tb/tb_eship_fire_scheduler.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/eship_fire_scheduler_pkg.sv
// Shared constants and types for the enemy-ship fire scheduler.
// The scheduler and its LFSR import everything from here.
package eship_fire_scheduler_pkg;

    localparam int NM  = 8;
    localparam int NPE = 4;

    localparam int         ESCHED_BASE_PERIOD = 60;
    localparam int         ESCHED_JITTER_BITS = 4;
    localparam logic [9:0] ESCHED_LFSR_SEED   = 10'h2A5;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        SCAN = 2'd1,
        FIRE = 2'd2
    } esched_state_t;

    // Next state of a left-shifting x^10+x^7+1 Fibonacci LFSR.
    function automatic logic [9:0] lfsr10Next(input logic [9:0] cur);
        return {cur[8:0], cur[9] ^ cur[6]};
    endfunction

endpackage

// File: rtl/eship_fire_scheduler_if.sv
// Game-side signals of the fire scheduler: run/alive/busy inputs in,
// fire request, countdown and last-shooter index out.
interface eship_fire_scheduler_if #(
    parameter int NM  = 8,
    parameter int NPE = 4
);
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;

    logic           Enable;
    logic [NM-1:0]  EShipAlive;
    logic [NPE-1:0] EProjOn;
    logic [NM-1:0]  ESchedFire;
    logic [9:0]     ESchedCtr;
    logic [IW-1:0]  ESchedIdx;

    modport master (
        output Enable, EShipAlive, EProjOn,
        input  ESchedFire, ESchedCtr, ESchedIdx
    );

    modport slave (
        input  Enable, EShipAlive, EProjOn,
        output ESchedFire, ESchedCtr, ESchedIdx
    );

endinterface

// File: rtl/eship_fire_scheduler_lfsr10.sv
// Seeded 10-bit Fibonacci LFSR that advances only when step is high.
// Provides the jitter added to the shot period.
module esched_lfsr10
    import eship_fire_scheduler_pkg::*;
#(
    parameter logic [9:0] LFSR_SEED = 10'h2A5
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       step,
    output logic [9:0] lfsr
);

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            lfsr <= LFSR_SEED;
        end else if (step) begin
            lfsr <= lfsr10Next(lfsr);
        end
    end

endmodule

// File: rtl/eship_fire_scheduler.sv
// Decides when an enemy ship fires and which one: jittered countdown,
// round-robin search over live ships, held off while all slots are busy.
module eship_fire_scheduler
    import eship_fire_scheduler_pkg::*;
#(
    parameter int         NM          = eship_fire_scheduler_pkg::NM,
    parameter int         NPE         = eship_fire_scheduler_pkg::NPE,
    parameter int         BASE_PERIOD = ESCHED_BASE_PERIOD,
    parameter int         JITTER_BITS = ESCHED_JITTER_BITS,
    parameter logic [9:0] LFSR_SEED   = ESCHED_LFSR_SEED
) (
    input  logic                  frame_clk,
    input  logic                  Reset,
    eship_fire_scheduler_if.slave bus
);

    localparam int         IW       = (NM > 1) ? $clog2(NM) : 1;
    localparam logic [IW-1:0] LAST  = IW'(NM - 1);
    localparam logic [9:0] BASE10   = 10'(BASE_PERIOD);

    if (NM < 1 || NM > 16) begin : gNmCheck
        $error("eship_fire_scheduler: NM must be in 1..16");
    end
    if (BASE_PERIOD + (1 << JITTER_BITS) - 1 > 1023) begin : gPeriodCheck
        $error("eship_fire_scheduler: BASE_PERIOD + 2^JITTER_BITS - 1 exceeds 1023");
    end
    if (LFSR_SEED == 10'd0) begin : gSeedCheck
        $error("eship_fire_scheduler: LFSR_SEED must be nonzero");
    end

    esched_state_t state, nextState;
    logic [9:0]    ctr, ctrNext;
    logic [IW-1:0] ptr, ptrNext;
    logic [IW-1:0] sel, selNext;
    logic [IW-1:0] scanCnt, scanCntNext;
    logic [9:0]    lfsr;
    logic [9:0]    reloadVal;
    logic          slotFree;
    logic          lfsrStep;
    logic          selAlive;

    function automatic logic [IW-1:0] wrapInc(input logic [IW-1:0] idx);
        return (idx == LAST) ? '0 : idx + 1'b1;
    endfunction

    esched_lfsr10 #(
        .LFSR_SEED(LFSR_SEED)
    ) uLfsr (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .step     (lfsrStep),
        .lfsr     (lfsr)
    );

    // Jitter comes from the low LFSR bits; zero jitter bits means a fixed period.
    if (JITTER_BITS == 0) begin : gNoJitter
        assign reloadVal = BASE10;
    end else begin : gJitter
        assign reloadVal = BASE10 + 10'(lfsr[JITTER_BITS-1:0]);
    end

    assign slotFree = ~&bus.EProjOn;
    assign selAlive = bus.EShipAlive[sel];
    assign lfsrStep = (state == FIRE);

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            state   <= WAIT;
            ctr     <= BASE10;
            ptr     <= LAST;
            sel     <= '0;
            scanCnt <= '0;
        end else begin
            state   <= nextState;
            ctr     <= ctrNext;
            ptr     <= ptrNext;
            sel     <= selNext;
            scanCnt <= scanCntNext;
        end
    end

    always_comb begin
        nextState   = state;
        ctrNext     = ctr;
        ptrNext     = ptr;
        selNext     = sel;
        scanCntNext = scanCnt;
        unique case (state)
            WAIT: begin
                if (!bus.Enable) begin
                    ctrNext = reloadVal;
                end else if (ctr != 10'd0) begin
                    ctrNext = ctr - 10'd1;
                end else if (slotFree) begin
                    nextState   = SCAN;
                    selNext     = wrapInc(ptr);
                    scanCntNext = '0;
                end
            end
            SCAN: begin
                if (!bus.Enable) begin
                    nextState = WAIT;
                    ctrNext   = reloadVal;
                end else if (selAlive) begin
                    nextState = FIRE;
                end else if (scanCnt == LAST) begin
                    nextState = WAIT;
                    ctrNext   = reloadVal;
                end else begin
                    selNext     = wrapInc(sel);
                    scanCntNext = scanCnt + 1'b1;
                end
            end
            FIRE: begin
                // A shot withheld by a dying ship or full slots still counts as taken.
                nextState = WAIT;
                ptrNext   = sel;
                ctrNext   = reloadVal;
            end
            default: begin
                nextState = WAIT;
            end
        endcase
    end

    always_comb begin
        bus.ESchedFire = '0;
        if (state == FIRE && selAlive && bus.Enable && slotFree) begin
            bus.ESchedFire[sel] = 1'b1;
        end
    end

    assign bus.ESchedCtr = ctr;
    assign bus.ESchedIdx = ptr;

endmodule

// File: tb/tb_eship_fire_scheduler.sv
// Randomised scoreboard bench: two scheduler configurations share stimulus
// and are compared every cycle against a behavioural model.
module tb_eship_fire_scheduler;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       en = 1'b1;
    logic [7:0] alive = 8'hFF;
    logic [3:0] proj = 4'h0;

    int nChecks = 0;
    int nFail   = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    eship_fire_scheduler_if #(.NM(8), .NPE(4)) ifA ();
    eship_fire_scheduler_if #(.NM(8), .NPE(4)) ifB ();

    assign ifA.Enable = en;
    assign ifA.EShipAlive = alive;
    assign ifA.EProjOn = proj;
    assign ifB.Enable = en;
    assign ifB.EShipAlive = alive;
    assign ifB.EProjOn = proj;

    eship_fire_scheduler #(
        .NM(8), .NPE(4), .BASE_PERIOD(60), .JITTER_BITS(4), .LFSR_SEED(10'h2A5)
    ) dutA (
        .frame_clk(clk),
        .Reset    (rstN),
        .bus      (ifA.slave)
    );

    eship_fire_scheduler #(
        .NM(8), .NPE(4), .BASE_PERIOD(4), .JITTER_BITS(0), .LFSR_SEED(10'h2A5)
    ) dutB (
        .frame_clk(clk),
        .Reset    (rstN),
        .bus      (ifB.slave)
    );

    // Reference model: per configuration, "busy" is 0 counting down, 1 hunting
    // for a live ship, 2 the single shooting frame.
    int mBase[2] = '{60, 4};
    int mJit[2]  = '{4, 0};
    int mBusy[2], mCtr[2], mLast[2], mCand[2], mTried[2], mLfsr[2];

    typedef struct {
        int         dut;
        int         cyc;
        logic [7:0] fire;
        int         ctr;
        int         idx;
    } exp_t;
    exp_t q[$];

    function automatic int reloadOf(int d);
        return mBase[d] + (mLfsr[d] % (1 << mJit[d]));
    endfunction

    task automatic modelEdge(int d);
        if (!rstN) begin
            mBusy[d] = 0; mCtr[d] = mBase[d]; mLast[d] = 7;
            mCand[d] = 0; mTried[d] = 0; mLfsr[d] = 'h2A5;
        end else if (mBusy[d] == 0) begin
            if (!en) mCtr[d] = reloadOf(d);
            else if (mCtr[d] > 0) mCtr[d] = mCtr[d] - 1;
            else if (proj != 4'hF) begin
                mBusy[d] = 1; mCand[d] = (mLast[d] + 1) % 8; mTried[d] = 0;
            end
        end else if (mBusy[d] == 1) begin
            if (!en) begin
                mBusy[d] = 0; mCtr[d] = reloadOf(d);
            end else if (alive[mCand[d]]) mBusy[d] = 2;
            else if (mTried[d] == 7) begin
                mBusy[d] = 0; mCtr[d] = reloadOf(d);
            end else begin
                mCand[d] = (mCand[d] + 1) % 8; mTried[d] = mTried[d] + 1;
            end
        end else begin
            mLast[d] = mCand[d];
            mCtr[d]  = reloadOf(d);
            mLfsr[d] = ((mLfsr[d] * 2) % 1024) + (((mLfsr[d] / 512) ^ (mLfsr[d] / 64)) % 2);
            mBusy[d] = 0;
        end
    endtask

    task automatic pushExp(int d);
        exp_t e;
        e.dut = d;
        e.cyc = cyc;
        e.fire = 8'h00;
        if (mBusy[d] == 2 && en && alive[mCand[d]] && proj != 4'hF) e.fire = 8'(1 << mCand[d]);
        e.ctr = mCtr[d];
        e.idx = mLast[d];
        q.push_back(e);
    endtask

    task automatic cycle(input logic r, input logic e, input logic [7:0] a, input logic [3:0] p);
        @(posedge clk);
        modelEdge(0);
        modelEdge(1);
        #1;
        rstN = r; en = e; alive = a; proj = p;
        cyc++;
        pushExp(0);
        pushExp(1);
    endtask

    task automatic chk(string nm, int c, int act, int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, c, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.dut == 0) begin
                chk("A.ESchedFire", e.cyc, int'(ifA.ESchedFire), int'(e.fire));
                chk("A.ESchedCtr", e.cyc, int'(ifA.ESchedCtr), e.ctr);
                chk("A.ESchedIdx", e.cyc, int'(ifA.ESchedIdx), e.idx);
            end else begin
                chk("B.ESchedFire", e.cyc, int'(ifB.ESchedFire), int'(e.fire));
                chk("B.ESchedCtr", e.cyc, int'(ifB.ESchedCtr), e.ctr);
                chk("B.ESchedIdx", e.cyc, int'(ifB.ESchedIdx), e.idx);
            end
        end
    end

    initial begin
        logic       r, e;
        logic [7:0] a;
        logic [3:0] p;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'hFF, 4'h0);
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1, 8'h01, 4'h0);
        for (int i = 0; i < 45; i++) cycle(1'b1, 1'b1, 8'hA4, 4'h0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 8'hFF, 4'hF);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 8'hFF, 4'hD);
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1, 8'h00, 4'h0);
        a = 8'h5A;
        for (int i = 0; i < 3500; i++) begin
            r = ($urandom_range(0, 399) != 0);
            e = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) a = 8'($urandom);
            p = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            cycle(r, e, a, p);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
